// File: rtl/eth_link_pacer.sv
// Ethernet TX pacing: PHY reset sequencing, debounced link-speed commit,
// byte-advance strobe generation and inter-frame-gap enforcement (clk125MHz domain).
//
// state    | meaning
// ST_HOLD  | eth_rst_b driven low, counting hold time
// ST_WAIT  | eth_rst_b released, waiting for PHY to settle
// ST_READY | PHY usable, phy_ready high
module eth_link_pacer #(
    parameter int          RST_HOLD_CYCLES     = 8388608,
    parameter int          RST_WAIT_CYCLES     = 8388608,
    parameter int          RST_CNT_W           = 24,
    parameter int          SPEED_STABLE_CYCLES = 1024,
    parameter int          DIV_100             = 10,
    parameter int          DIV_10              = 100,
    parameter int          DIV_W               = 7,
    parameter int          IFG_BYTES           = 12,
    parameter logic [1:0]  RESET_SPEED         = 2'b11
) (
    input  logic       clk125MHz,
    input  logic       rstb,
    input  logic       soft_rst,
    input  logic       link_10mb,
    input  logic       link_100mb,
    input  logic       link_1000mb,
    input  logic       speed_override_en,
    input  logic [1:0] speed_override,
    input  logic       frame_active,
    output logic       eth_rst_b,
    output logic       phy_ready,
    output logic [1:0] speed,
    output logic       adv_data,
    output logic       speed_changed,
    output logic       tx_allowed
);

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    localparam logic [RST_CNT_W-1:0] HOLD_LAST = RST_CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [RST_CNT_W-1:0] WAIT_LAST = RST_CNT_W'(RST_WAIT_CYCLES - 1);

    localparam int STAB_W = $clog2(SPEED_STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(SPEED_STABLE_CYCLES);

    localparam int IFG_W = $clog2(IFG_BYTES + 1);
    localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_BYTES);

    logic [1:0]           r_state;
    logic [RST_CNT_W-1:0] r_rst_cnt;
    logic                 r_eth_rst_b;
    logic                 r_phy_ready;

    logic [2:0]           r_sync1;
    logic [2:0]           r_sync2;
    logic [1:0]           r_det;
    logic [STAB_W-1:0]    r_stab;

    logic [1:0]           r_speed;
    logic                 r_speed_changed;
    logic [DIV_W-1:0]     r_cnt;
    logic                 r_adv;

    logic                 r_frame_d;
    logic [IFG_W-1:0]     r_ifg;
    logic                 r_tx_allowed;

    logic [1:0]           w_det;
    logic                 w_run_ok;
    logic [STAB_W-1:0]    w_stab_next;
    logic [1:0]           w_cand;
    logic                 w_elig;
    logic                 w_commit;
    logic [DIV_W-1:0]     w_div_last;
    logic                 w_frame_fall;

    // Reset sequencer; soft_rst restarts it from HOLD regardless of state.
    always_ff @(posedge clk125MHz or negedge rstb) begin
        if (!rstb) begin
            r_state     <= ST_HOLD;
            r_rst_cnt   <= '0;
            r_eth_rst_b <= 1'b0;
            r_phy_ready <= 1'b0;
        end else if (soft_rst) begin
            r_state     <= ST_HOLD;
            r_rst_cnt   <= '0;
            r_eth_rst_b <= 1'b0;
            r_phy_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_rst_cnt == HOLD_LAST) begin
                        r_state     <= ST_WAIT;
                        r_rst_cnt   <= '0;
                        r_eth_rst_b <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_rst_cnt == WAIT_LAST) begin
                        r_state     <= ST_READY;
                        r_rst_cnt   <= '0;
                        r_phy_ready <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    r_rst_cnt <= '0;
                end
                default: begin
                    r_state     <= ST_HOLD;
                    r_rst_cnt   <= '0;
                    r_eth_rst_b <= 1'b0;
                    r_phy_ready <= 1'b0;
                end
            endcase
        end
    end

    // Link loss keeps the last detected speed rather than dropping to 00.
    always_comb begin
        w_det = r_det;
        if (r_sync2[2]) begin
            w_det = 2'b11;
        end else if (r_sync2[1]) begin
            w_det = 2'b10;
        end else if (r_sync2[0]) begin
            w_det = 2'b01;
        end
    end

    // Run length only accumulates while the detected value is a real change request.
    always_comb begin
        w_run_ok    = !speed_override_en && (w_det != r_speed);
        w_stab_next = '0;
        if (w_run_ok) begin
            if (w_det != r_det) begin
                w_stab_next = STAB_W'(1);
            end else if (r_stab == STAB_MAX) begin
                w_stab_next = r_stab;
            end else begin
                w_stab_next = r_stab + 1'b1;
            end
        end
    end

    always_comb begin
        if (speed_override_en) begin
            w_cand = speed_override;
            w_elig = 1'b1;
        end else begin
            w_cand = w_det;
            w_elig = (w_stab_next == STAB_MAX);
        end
        w_commit = w_elig && !frame_active && (w_cand != r_speed);
    end

    always_ff @(posedge clk125MHz or negedge rstb) begin
        if (!rstb) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_det   <= RESET_SPEED;
            r_stab  <= '0;
        end else begin
            r_sync1 <= {link_1000mb, link_100mb, link_10mb};
            r_sync2 <= r_sync1;
            r_det   <= w_det;
            r_stab  <= w_stab_next;
        end
    end

    always_comb begin
        case (r_speed)
            2'b10:   w_div_last = DIV_W'(DIV_100 - 1);
            2'b01:   w_div_last = DIV_W'(DIV_10 - 1);
            default: w_div_last = '0;
        endcase
    end

    // A commit realigns the divider so the first byte at the new rate is a full period.
    always_ff @(posedge clk125MHz or negedge rstb) begin
        if (!rstb) begin
            r_speed         <= RESET_SPEED;
            r_speed_changed <= 1'b0;
            r_cnt           <= '0;
            r_adv           <= 1'b0;
        end else begin
            r_speed_changed <= w_commit;
            r_adv           <= (r_speed != 2'b00) && (r_cnt == '0);
            if (w_commit) begin
                r_speed <= w_cand;
                r_cnt   <= '0;
            end else if (r_cnt >= w_div_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_frame_fall = r_frame_d && !frame_active;

    always_ff @(posedge clk125MHz or negedge rstb) begin
        if (!rstb) begin
            r_frame_d    <= 1'b0;
            r_ifg        <= '0;
            r_tx_allowed <= 1'b0;
        end else begin
            r_frame_d    <= frame_active;
            r_tx_allowed <= !soft_rst && r_phy_ready && (r_ifg == '0) && (r_speed != 2'b00);
            if (w_frame_fall) begin
                r_ifg <= IFG_LOAD;
            end else if (r_adv && (r_ifg != '0)) begin
                r_ifg <= r_ifg - 1'b1;
            end
        end
    end

    assign eth_rst_b     = r_eth_rst_b;
    assign phy_ready     = r_phy_ready;
    assign speed         = r_speed;
    assign adv_data      = r_adv;
    assign speed_changed = r_speed_changed;
    assign tx_allowed    = r_tx_allowed;

endmodule

// File: tb/tb_eth_link_pacer.sv
// Bench for eth_link_pacer: directed timing checks plus randomized traffic,
// with every cycle's outputs scored against a reference model through a queue.
module tb_eth_link_pacer;

    localparam int HOLD   = 16;
    localparam int WAITC  = 16;
    localparam int STABLE = 8;
    localparam int IFG    = 12;

    logic       clk;
    logic       rstb;
    logic       soft_rst;
    logic       link_10mb;
    logic       link_100mb;
    logic       link_1000mb;
    logic       speed_override_en;
    logic [1:0] speed_override;
    logic       frame_active;
    logic       eth_rst_b;
    logic       phy_ready;
    logic [1:0] speed;
    logic       adv_data;
    logic       speed_changed;
    logic       tx_allowed;

    int n_checks = 0;
    int n_errors = 0;

    eth_link_pacer #(
        .RST_HOLD_CYCLES(HOLD),
        .RST_WAIT_CYCLES(WAITC),
        .RST_CNT_W(24),
        .SPEED_STABLE_CYCLES(STABLE),
        .DIV_100(10),
        .DIV_10(100),
        .DIV_W(7),
        .IFG_BYTES(IFG),
        .RESET_SPEED(2'b11)
    ) dut (
        .clk125MHz(clk),
        .rstb(rstb),
        .soft_rst(soft_rst),
        .link_10mb(link_10mb),
        .link_100mb(link_100mb),
        .link_1000mb(link_1000mb),
        .speed_override_en(speed_override_en),
        .speed_override(speed_override),
        .frame_active(frame_active),
        .eth_rst_b(eth_rst_b),
        .phy_ready(phy_ready),
        .speed(speed),
        .adv_data(adv_data),
        .speed_changed(speed_changed),
        .tx_allowed(tx_allowed)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Reset sequencing is elapsed time since the last (soft) reset; the byte
    // divider is elapsed time since the last commit modulo the byte period.
    logic [6:0] exp_q[$];
    logic [2:0] m_h1, m_h2;
    logic [1:0] m_det_prev, m_speed;
    logic       m_adv, m_fa_prev;
    int         m_run, m_since, m_t, m_ifg;

    task automatic model_init();
        m_h1 = '0; m_h2 = '0;
        m_det_prev = 2'b11; m_speed = 2'b11;
        m_adv = 1'b0; m_fa_prev = 1'b0;
        m_run = 0; m_since = 0; m_t = 0; m_ifg = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [1:0] det, cand;
        logic       elig, commit, adv_n, tx_n;
        int         div;
        if (m_h2[2])      det = 2'b11;
        else if (m_h2[1]) det = 2'b10;
        else if (m_h2[0]) det = 2'b01;
        else              det = m_det_prev;
        if (speed_override_en || det == m_speed) m_run = 0;
        else if (det != m_det_prev)             m_run = 1;
        else if (m_run < STABLE)                m_run = m_run + 1;
        cand   = speed_override_en ? speed_override : det;
        elig   = speed_override_en ? 1'b1 : (m_run >= STABLE);
        commit = elig && !frame_active && (cand != m_speed);
        div    = (m_speed == 2'b10) ? 10 : (m_speed == 2'b01) ? 100 : 1;
        adv_n  = (m_speed != 2'b00) && ((m_since % div) == 0);
        tx_n   = !soft_rst && (m_t >= HOLD + WAITC) && (m_ifg == 0) && (m_speed != 2'b00);
        if (m_fa_prev && !frame_active) m_ifg = IFG;
        else if (m_adv && m_ifg > 0)    m_ifg = m_ifg - 1;
        m_t = soft_rst ? 0 : ((m_t < 1000) ? m_t + 1 : m_t);
        if (commit) begin
            m_speed = cand;
            m_since = 0;
        end else begin
            m_since = m_since + 1;
        end
        m_adv      = adv_n;
        m_det_prev = det;
        m_h2       = m_h1;
        m_h1       = {link_1000mb, link_100mb, link_10mb};
        m_fa_prev  = frame_active;
        exp_q.push_back({m_t >= HOLD, m_t >= HOLD + WAITC, m_speed, adv_n, commit, tx_n});
    endtask

    always @(posedge clk) begin
        if (!rstb) model_init();
        else       model_step();
    end

    // ---------------- monitor ----------------
    task automatic mon_reset();
        check("reset_values", int'({eth_rst_b, phy_ready, speed, adv_data, speed_changed, tx_allowed}),
              int'(7'b0011000));
    endtask

    task automatic mon_pop();
        logic [6:0] e;
        e = exp_q.pop_front();
        check("outputs{eth,phy,spd,adv,chg,tx}",
              int'({eth_rst_b, phy_ready, speed, adv_data, speed_changed, tx_allowed}), int'(e));
    endtask

    always @(negedge clk) begin
        if (!rstb)                 mon_reset();
        else if (exp_q.size() > 0) mon_pop();
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return eth_rst_b;
            1:       return phy_ready;
            2:       return tx_allowed;
            3:       return speed_changed;
            default: return adv_data;
        endcase
    endfunction

    // Edges until sig(sel)==val; -1 when the bound expires.
    task automatic wait_sig(input int sel, input logic val, input int limit, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (sig(sel) != val && n < limit);
        if (sig(sel) != val) n = -1;
    endtask

    task automatic count_tx_low(input int limit, output int low);
        low = 0;
        for (int k = 0; k < limit; k++) begin
            tick(1);
            if (!tx_allowed) low++;
            else if (low > 0) break;
        end
    endtask

    initial begin
        int n;
        rstb = 1'b0; soft_rst = 1'b0;
        link_10mb = 1'b0; link_100mb = 1'b0; link_1000mb = 1'b0;
        speed_override_en = 1'b0; speed_override = 2'b00; frame_active = 1'b0;
        tick(3);
        rstb = 1'b1;

        wait_sig(0, 1'b1, 100, n); check("eth_rst_b_rise", n, HOLD);
        wait_sig(1, 1'b1, 100, n); check("phy_ready_rise", n, WAITC);
        wait_sig(2, 1'b1, 10, n);  check("tx_allowed_rise", n, 1);
        check("speed_after_reset", int'(speed), 3);
        check("adv_const_1000", int'(adv_data), 1);

        link_100mb = 1'b1;
        wait_sig(3, 1'b1, 50, n);  check("commit_100_latency", n, 2 + STABLE);
        check("speed_100", int'(speed), 2);
        wait_sig(4, 1'b1, 200, n);
        wait_sig(4, 1'b1, 200, n); check("adv_period_100", n, 10);

        link_100mb = 1'b0; link_10mb = 1'b1;
        wait_sig(3, 1'b1, 50, n);  check("commit_10_latency", n, 2 + STABLE);
        check("speed_10", int'(speed), 1);
        wait_sig(4, 1'b1, 200, n);
        wait_sig(4, 1'b1, 200, n); check("adv_period_10", n, 100);

        link_10mb = 1'b0; link_1000mb = 1'b1; frame_active = 1'b1;
        tick(50);
        check("speed_deferred_in_frame", int'(speed), 1);
        frame_active = 1'b0;
        wait_sig(3, 1'b1, 5, n);   check("commit_on_first_idle", n, 1);
        check("speed_1000", int'(speed), 3);
        tick(20);
        frame_active = 1'b1; tick(5); frame_active = 1'b0;
        count_tx_low(60, n);       check("ifg_1000_low_cycles", n, IFG);

        link_1000mb = 1'b0; link_100mb = 1'b1;
        wait_sig(3, 1'b1, 50, n);  check("commit_100_again", n, 2 + STABLE);
        frame_active = 1'b1; tick(5); frame_active = 1'b0;
        count_tx_low(300, n);      check("ifg_100_low_in_range", int'(n >= 111 && n <= 120), 1);

        frame_active = 1'b1; tick(3);
        soft_rst = 1'b1; tick(1);
        check("soft_eth_rst_b", int'(eth_rst_b), 0);
        check("soft_phy_ready", int'(phy_ready), 0);
        check("soft_tx_allowed", int'(tx_allowed), 0);
        check("soft_speed_kept", int'(speed), 2);
        soft_rst = 1'b0;
        wait_sig(0, 1'b1, 40, n);  check("soft_eth_rise", n, HOLD);
        wait_sig(1, 1'b1, 40, n);  check("soft_phy_rise", n, WAITC);
        frame_active = 1'b0;
        tick(2);

        link_100mb = 1'b0; link_1000mb = 1'b1;
        speed_override_en = 1'b1; speed_override = 2'b01;
        wait_sig(3, 1'b1, 5, n);   check("override_commit", n, 1);
        check("override_speed", int'(speed), 1);
        wait_sig(4, 1'b1, 200, n);
        wait_sig(4, 1'b1, 200, n); check("override_period", n, 100);
        speed_override_en = 1'b0;
        wait_sig(3, 1'b1, 30, n);  check("override_release_delay", n, STABLE);
        check("override_release_speed", int'(speed), 3);

        for (int seg = 0; seg < 250; seg++) begin
            int r;
            int len;
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                {link_1000mb, link_100mb, link_10mb} = 3'($urandom_range(0, 7));
            end else if (r < 16) begin
                speed_override_en = 1'($urandom_range(0, 1));
                speed_override    = 2'($urandom_range(0, 3));
            end else if (r < 19) begin
                soft_rst = 1'b1; tick(1); soft_rst = 1'b0;
            end else if (r < 65) begin
                if (tx_allowed || r < 22) begin
                    len = int'($urandom_range(1, 40));
                    frame_active = 1'b1;
                    repeat (len) begin
                        soft_rst = ($urandom_range(0, 199) == 0);
                        tick(1);
                    end
                    soft_rst = 1'b0;
                    frame_active = 1'b0;
                end
            end
            tick(int'($urandom_range(1, 30)));
        end
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_link_pacer.md
Name: eth_link_pacer

Overview:
- Parametrised successor to the Ethernet TX control logic: PHY reset sequencing, link-speed selection and byte-advance strobe generation in one block.
- Adds capabilities the current logic lacks:
  - configurable reset timing and soft re-reset;
  - debounced, frame-safe speed changes;
  - a manual speed override;
  - inter-frame-gap (IFG) enforcement counted in byte times.
- Sits between rgmii_rx link status, byte_data and ethernet_tx, all in the 125 MHz TX domain.

Parameters:
RST_HOLD_CYCLES, 8388608, cycles eth_rst_b held low after reset/soft_rst
RST_WAIT_CYCLES, 8388608, cycles after eth_rst_b rises before phy_ready
RST_CNT_W, 24, width of reset sequencer counter (must hold max of the two above)
SPEED_STABLE_CYCLES, 1024, cycles a new detected speed must persist before commit
DIV_100, 10, clk125MHz cycles per byte at 100 Mb/s
DIV_10, 100, clk125MHz cycles per byte at 10 Mb/s
DIV_W, 7, width of advance divider counter
IFG_BYTES, 12, minimum gap in byte times between frames
RESET_SPEED, 2'b11, speed code after reset

Ports:
clk125MHz  in  1  TX clock
rstb  in  1  asynchronous active-low reset
soft_rst  in  1  sync pulse; restarts PHY reset sequence
link_10mb  in  1  from rgmii_rx (rx_clk domain)
link_100mb  in  1  from rgmii_rx (rx_clk domain)
link_1000mb  in  1  from rgmii_rx (rx_clk domain)
speed_override_en  in  1  use speed_override instead of detected link
speed_override  in  2  forced speed code
frame_active  in  1  high while byte_data drives a frame (raw_data_enable)
eth_rst_b  out  1  PHY reset, active low
phy_ready  out  1  PHY out of reset and settled
speed  out  2  committed speed code: 11=1000, 10=100, 01=10, 00=none
adv_data  out  1  one-cycle byte-advance strobe
speed_changed  out  1  one-cycle pulse on speed commit
tx_allowed  out  1  a new frame may start

Behaviour:
- Reset (rstb=0) values:
  - eth_rst_b=0, phy_ready=0, speed=RESET_SPEED, adv_data=0, speed_changed=0, tx_allowed=0.
  - All counters 0, FSM in HOLD.
- Reset FSM states HOLD, WAIT, READY:
  - HOLD: eth_rst_b=0; after RST_HOLD_CYCLES cycles go to WAIT.
  - WAIT: eth_rst_b=1; after RST_WAIT_CYCLES cycles go to READY.
  - READY: phy_ready=1.
  - All outputs are registered. Cycle counts are exact from rstb release.
  - soft_rst in any state: next cycle FSM enters HOLD, counter cleared, eth_rst_b=0 and phy_ready=0. soft_rst during HOLD restarts the count.
- Link inputs: each passes through a 2-flop synchroniser.
  - Detected speed priority: 1000 > 100 > 10.
  - If no link bit is set, the detected value holds its previous value; it never drops to 00 from link loss.
- Speed candidate:
  - Stability counter clears whenever the detected speed changes.
  - Candidate is eligible once the detected speed equals the same value, which differs from speed, for SPEED_STABLE_CYCLES consecutive cycles.
- Override: when speed_override_en=1, the candidate is speed_override and is eligible immediately (no stability delay).
- Commit:
  - Happens only in a cycle with frame_active=0; otherwise it is deferred until frame_active=0.
  - On commit: speed updates, speed_changed=1 for exactly one cycle, divider counter reset to 0.
  - Committing a value equal to speed is a no-op with no pulse.
- Divider / adv_data:
  - Counter cnt runs 0..DIV-1 and wraps.
  - adv_data is registered: high in the cycle after cnt==0.
  - 11: adv_data constantly 1 (from the second cycle after rstb release).
  - 10: period DIV_100, duty 1 cycle.
  - 01: period DIV_10, duty 1 cycle.
  - 00: adv_data=0, cnt held at 0.
- IFG:
  - On a 1->0 transition of frame_active, ifg_cnt loads IFG_BYTES.
  - ifg_cnt decrements by 1 per adv_data strobe, saturating at 0.
  - A speed change mid-gap keeps the count; remaining bytes elapse at the new rate.
  - tx_allowed = phy_ready & (ifg_cnt==0) & (speed!=00), registered.
  - frame_active rising while tx_allowed=0 is a protocol error: it is ignored; there is no reload until the next falling edge.
- Simultaneous events:
  - soft_rst and a speed commit in the same cycle: both take effect.
  - A frame_active fall in the same cycle as a commit: the IFG load uses the new speed's strobes.

Test Plan:
- Params: RST_HOLD=16, RST_WAIT=16, SPEED_STABLE=8. Release rstb -> eth_rst_b rises exactly 16 cycles later; phy_ready rises 32 cycles later; tx_allowed follows 1 cycle after phy_ready; speed=11; adv_data constantly 1.
- link_100mb=1 only, frame_active=0 -> speed=10 and a single speed_changed pulse at 2 sync + 8 stable cycles; adv_data period then exactly 10 cycles. Repeat with link_10mb -> period 100.
- Speed change request during frame_active=1 for 50 cycles -> speed unchanged until the first cycle frame_active=0, then commit and pulse.
- At speed 10, frame_active falls -> tx_allowed low for exactly 12 adv_data strobes (about 120 cycles), then high. At speed 11 -> gap of 12 cycles.
- soft_rst while READY, mid-frame -> next cycle eth_rst_b=0, phy_ready=0, tx_allowed=0; the full 16+16 sequence repeats; speed is retained.
- speed_override_en=1, speed_override=01 while link_1000mb=1 -> commit on the next idle cycle with no stability delay; adv_data period 100. Deassert the override -> return to 11 after the stability delay.
